// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : HI/LO multiply/divide sequencer for the pipelined MIPS core.
//                Fixed-latency multiply (with MADD/MSUB accumulate), iterative
//                radix-2 restoring divider, owns the HI/LO registers and stalls
//                the pipeline while a dependent instruction waits in EX.
//  Ports       : clk, rst       - clock / synchronous active-high reset
//                op_valid, op   - EX-stage unit op and its 4-bit code
//                a, b           - rs / rt operands
//                read_req       - EX instruction reads HI/LO
//                cancel         - exception flush
//                stall, busy    - pipeline hold / operation in flight
//                done           - one-cycle pulse after a multi-cycle HI/LO write
//                hi, lo         - HI and LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_ITER    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        read_req,
    input  logic        cancel,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_ACC  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_FIX  = 3'd4;

    // Wide enough for DIV_ITER (32) and any legal multiply latency.
    localparam int CW = 6;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_done;
    logic [63:0]   r_prod;
    logic          r_is_acc;    // MADD/MSUB: go through ACC after the multiply
    logic          r_is_sub;    // MSUB: subtract product from HI/LO
    logic [31:0]   r_quo;       // dividend shifts out the top, quotient bits in
    logic [31:0]   r_rem;
    logic [31:0]   r_dvs;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_dz;

    logic          w_busy;
    logic          w_accept;
    logic          w_sgn;
    logic [63:0]   w_ax;
    logic [63:0]   w_bx;
    logic [63:0]   w_prod;
    logic [31:0]   w_a_mag;
    logic [31:0]   w_b_mag;
    logic [63:0]   w_acc;
    logic [32:0]   w_rem_sh;
    logic [32:0]   w_diff;
    logic          w_ge;
    logic [31:0]   w_q_fix;
    logic [31:0]   w_r_fix;

    assign w_busy   = (r_state != S_IDLE);
    assign stall    = w_busy & (op_valid | read_req);
    assign w_accept = op_valid & ~stall & ~cancel;

    // Even op codes in the multiply/divide group are the signed variants.
    assign w_sgn   = ~op[0];
    assign w_ax    = {{32{w_sgn & a[31]}}, a};
    assign w_bx    = {{32{w_sgn & b[31]}}, b};
    assign w_prod  = w_ax * w_bx;
    assign w_a_mag = (w_sgn & a[31]) ? -a : a;
    assign w_b_mag = (w_sgn & b[31]) ? -b : b;

    assign w_acc = r_is_sub ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);

    // Restoring step: partial remainder stays below the divisor, so the
    // doubled value fits in 33 bits and bit 32 of the difference is the borrow.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[32];

    // Divide by zero leaves the dividend magnitude as remainder, so the
    // remainder sign fix-up already reproduces a; only the quotient is forced.
    assign w_q_fix = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? -r_quo : r_quo);
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_prod   <= '0;
            r_is_acc <= 1'b0;
            r_is_sub <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        casez (op)
                            4'b0110: r_hi <= a;
                            4'b0100: r_lo <= a;
                            4'b100?, 4'b11??: begin
                                r_prod   <= w_prod;
                                r_is_acc <= op[2];
                                r_is_sub <= op[1];
                                r_cnt    <= CW'(MUL_LATENCY - 1);
                                r_state  <= S_MUL;
                            end
                            4'b101?: begin
                                r_quo   <= w_a_mag;
                                r_rem   <= '0;
                                r_dvs   <= w_b_mag;
                                r_neg_q <= w_sgn & (a[31] ^ b[31]);
                                r_neg_r <= w_sgn & a[31];
                                r_dz    <= (b == 32'd0);
                                r_cnt   <= CW'(DIV_ITER);
                                r_state <= S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == CW'(1)) begin
                        if (r_is_acc) begin
                            r_state <= S_ACC;
                        end else begin
                            {r_hi, r_lo} <= r_prod;
                            r_done       <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ACC: begin
                    if (!cancel) begin
                        {r_hi, r_lo} <= w_acc;
                        r_done       <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                S_DIV: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
                        r_quo <= {r_quo[30:0], w_ge};
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        r_lo   <= w_q_fix;
                        r_hi   <= w_r_fix;
                        r_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
